// File: rtl/ram_pkg.sv
// Shared definitions for the byte-lane data RAM: default widths, the
// sequencer state encoding and the lane-count helper.
package ram_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int RV32_ADDR_WIDTH        = 32;
  localparam int DEFAULT_RAM_ADDR_WIDTH = 12;

  // CLEAR zero-fills the array after reset, RUN serves bus traffic.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ram_state_e;

  // Number of byte lanes in a data word.
  function automatic int lane_count(input int data_width, input int lane_width);
    return data_width / lane_width;
  endfunction

endpackage

// File: rtl/sdp_bram_lane.sv
// One byte lane of the data RAM: simple dual-port array with a synchronous
// write port and a registered read port. Contents are never reset; a read and
// a write to the same word in one cycle return the previously stored value.
module sdp_bram_lane #(
  parameter int  LANE_WIDTH = 8,
  parameter int  ADDR_WIDTH = 10,
  localparam int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [LANE_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [LANE_WIDTH-1:0] rd_data
);

  logic [LANE_WIDTH-1:0] mem_r [DEPTH];

  // Write port: commit the lane byte at the clock edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port: capture the stored byte; held until the next read.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/ram_lanes.sv
// Parametrised byte-lane data RAM with valid/ready request ports, a post-reset
// zero-fill sequencer, per-lane write-first forwarding for same-cycle
// read/write of one word, out-of-range flagging and an optional output stage.
module ram_lanes
  import ram_pkg::*;
#(
  parameter int  DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int  LANE_WIDTH     = 8,
  parameter int  RAM_ADDR_WIDTH = DEFAULT_RAM_ADDR_WIDTH,
  parameter int  BUS_ADDR_WIDTH = RV32_ADDR_WIDTH,
  parameter int  OUT_REG        = 0,
  parameter int  CLEAR_ON_RESET = 1,
  localparam int NUM_LANES      = lane_count(DATA_WIDTH, LANE_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_req_i,
  input  logic [NUM_LANES-1:0]      wr_be_i,
  input  logic [BUS_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]     wr_data_i,
  output logic                      wr_ready_o,
  input  logic                      rd_req_i,
  input  logic [BUS_ADDR_WIDTH-1:0] rd_addr_i,
  output logic                      rd_ready_o,
  output logic [DATA_WIDTH-1:0]     rd_data_o,
  output logic                      rd_valid_o,
  output logic                      err_o
);

  localparam int LANE_BITS = $clog2(NUM_LANES);
  localparam int WORD_AW   = RAM_ADDR_WIDTH - LANE_BITS;
  localparam logic [WORD_AW-1:0] CLR_LAST = {WORD_AW{1'b1}};
  localparam ram_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  // ---------------------------------------------------------------------
  // Address decode and handshakes
  // ---------------------------------------------------------------------
  logic               ready_r;
  logic [WORD_AW-1:0] wr_idx_s;
  logic [WORD_AW-1:0] rd_idx_s;
  logic               wr_oor_s;
  logic               rd_oor_s;
  logic               wr_fire_s;
  logic               rd_fire_s;
  logic               wr_err_s;
  logic               rd_err_s;

  assign wr_idx_s  = wr_addr_i[RAM_ADDR_WIDTH-1:LANE_BITS];
  assign rd_idx_s  = rd_addr_i[RAM_ADDR_WIDTH-1:LANE_BITS];
  assign wr_oor_s  = |wr_addr_i[BUS_ADDR_WIDTH-1:RAM_ADDR_WIDTH];
  assign rd_oor_s  = |rd_addr_i[BUS_ADDR_WIDTH-1:RAM_ADDR_WIDTH];
  assign wr_fire_s = wr_req_i & ready_r;
  assign rd_fire_s = rd_req_i & ready_r;
  assign wr_err_s  = wr_fire_s & wr_oor_s;
  assign rd_err_s  = rd_fire_s & rd_oor_s;

  assign wr_ready_o = ready_r;
  assign rd_ready_o = ready_r;

  // Lane-select address bits carry no information: strobes are pre-shifted.
  if (LANE_BITS > 0) begin : g_lane_bits
    logic unused_lane_bits_s;
    assign unused_lane_bits_s = ^{wr_addr_i[LANE_BITS-1:0], rd_addr_i[LANE_BITS-1:0]};
  end

  // ---------------------------------------------------------------------
  // Zero-fill sequencer
  // ---------------------------------------------------------------------
  ram_state_e         state_r;
  ram_state_e         state_nxt_s;
  logic [WORD_AW-1:0] clr_idx_r;
  logic               clr_active_s;
  logic               ready_nxt_s;

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: leave CLEAR once the last word has been written.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_idx_r == CLR_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = RESET_STATE;
    endcase
  end

  // Sequencer outputs: clear-write enable and the next value of ready.
  always_comb begin
    clr_active_s = 1'b0;
    ready_nxt_s  = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        clr_active_s = 1'b1;
        ready_nxt_s  = (clr_idx_r == CLR_LAST);
      end
      ST_RUN: begin
        clr_active_s = 1'b0;
        ready_nxt_s  = 1'b1;
      end
      default: begin
        clr_active_s = 1'b0;
        ready_nxt_s  = 1'b0;
      end
    endcase
  end

  // Ready is registered so it stays low until the first edge after reset,
  // even when no clear sequence runs; the clear index walks the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r   <= 1'b0;
      clr_idx_r <= {WORD_AW{1'b0}};
    end else begin
      ready_r <= ready_nxt_s;
      if (clr_active_s) begin
        clr_idx_r <= clr_idx_r + WORD_AW'(1'b1);
      end else begin
        clr_idx_r <= {WORD_AW{1'b0}};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Lane arrays and write-port mux
  // ---------------------------------------------------------------------
  logic [NUM_LANES-1:0]  mem_we_s;
  logic [WORD_AW-1:0]    mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic [DATA_WIDTH-1:0] bram_q_s;

  // Write port source: clear sequencer during CLEAR, bus writes otherwise.
  always_comb begin
    if (clr_active_s) begin
      mem_we_s    = {NUM_LANES{1'b1}};
      mem_waddr_s = clr_idx_r;
      mem_wdata_s = {DATA_WIDTH{1'b0}};
    end else begin
      mem_we_s    = (wr_fire_s && !wr_oor_s) ? wr_be_i : {NUM_LANES{1'b0}};
      mem_waddr_s = wr_idx_s;
      mem_wdata_s = wr_data_i;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    sdp_bram_lane #(
      .LANE_WIDTH (LANE_WIDTH),
      .ADDR_WIDTH (WORD_AW)
    ) u_lane (
      .clk     (clk),
      .wr_en   (mem_we_s[k]),
      .wr_addr (mem_waddr_s),
      .wr_data (mem_wdata_s[k*LANE_WIDTH +: LANE_WIDTH]),
      .rd_en   (rd_fire_s),
      .rd_addr (rd_idx_s),
      .rd_data (bram_q_s[k*LANE_WIDTH +: LANE_WIDTH])
    );
  end

  // ---------------------------------------------------------------------
  // Read stage 1: forwarding and range bookkeeping
  // ---------------------------------------------------------------------
  logic [NUM_LANES-1:0]  fwd_mask_s;
  logic [NUM_LANES-1:0]  fwd_mask_r;
  logic [DATA_WIDTH-1:0] fwd_data_r;
  logic                  s1_valid_r;
  logic                  s1_zero_r;
  logic [DATA_WIDTH-1:0] s1_data_s;

  assign fwd_mask_s = (wr_fire_s && !wr_oor_s && (wr_idx_s == rd_idx_s)) ?
                      wr_be_i : {NUM_LANES{1'b0}};

  // Capture forwarding lanes and range status with the read itself, so a
  // later write cannot disturb a result already in flight. The zero flag
  // resets high so the data output reads as zero before the first read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_zero_r  <= 1'b1;
      fwd_mask_r <= {NUM_LANES{1'b0}};
      fwd_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      s1_valid_r <= rd_fire_s;
      if (rd_fire_s) begin
        s1_zero_r  <= rd_oor_s;
        fwd_mask_r <= fwd_mask_s;
        fwd_data_r <= wr_data_i;
      end
    end
  end

  // Per-lane select: zero for out-of-range, new data on strobed lanes,
  // stored data otherwise.
  always_comb begin
    s1_data_s = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < NUM_LANES; k++) begin
      if (s1_zero_r) begin
        s1_data_s[k*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{1'b0}};
      end else if (fwd_mask_r[k]) begin
        s1_data_s[k*LANE_WIDTH +: LANE_WIDTH] = fwd_data_r[k*LANE_WIDTH +: LANE_WIDTH];
      end else begin
        s1_data_s[k*LANE_WIDTH +: LANE_WIDTH] = bram_q_s[k*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_out_reg
    logic                  rd_valid_r;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  err_r;

    // Extra register stage; data only reloads on a valid beat. Write errors
    // still report the cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_valid_r <= 1'b0;
        rd_data_r  <= {DATA_WIDTH{1'b0}};
        err_r      <= 1'b0;
      end else begin
        rd_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          rd_data_r <= s1_data_s;
        end
        err_r <= wr_err_s | (s1_valid_r & s1_zero_r);
      end
    end

    assign rd_valid_o = rd_valid_r;
    assign rd_data_o  = rd_data_r;
    assign err_o      = err_r;
  end else begin : g_no_out_reg
    logic err_r;

    // Error pulse lands together with the read-valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        err_r <= 1'b0;
      end else begin
        err_r <= wr_err_s | rd_err_s;
      end
    end

    assign rd_valid_o = s1_valid_r;
    assign rd_data_o  = s1_data_s;
    assign err_o      = err_r;
  end

endmodule

// File: doc/ram_lanes.md
# ram_lanes

Parametrised byte-lane data RAM for the TinyRISC-V peripheral bus. It succeeds the fixed 4×8-bit RAM with configurable lane count and depth, and uses valid/ready request handshakes. It adds a post-reset zero-fill sequencer, an optional output register stage, and same-cycle read-during-write forwarding per lane. Out-of-range addresses are flagged. The block sits behind the bus arbiter as the core's data memory.

## Interface
- `DATA_WIDTH`, 32: word width; must be a multiple of `LANE_WIDTH`.
- `LANE_WIDTH`, 8: bits per byte lane. `NUM_LANES = DATA_WIDTH/LANE_WIDTH`.
- `RAM_ADDR_WIDTH`, 12: byte-address bits decoded. `DEPTH = 2^(RAM_ADDR_WIDTH - log2(NUM_LANES))` words.
- `BUS_ADDR_WIDTH`, 32: width of incoming bus address.
- `OUT_REG`, 0: 1 adds an output register; read latency becomes 2.
- `CLEAR_ON_RESET`, 1: 1 zero-fills all words after reset.

Ports:
- `clk`  in  1  single clock for both ports.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_req_i`  in  1  write request valid.
- `wr_be_i`  in  NUM_LANES  per-lane write strobe.
- `wr_addr_i`  in  BUS_ADDR_WIDTH  byte address.
- `wr_data_i`  in  DATA_WIDTH  write data; lane k = bits [k*LANE_WIDTH +: LANE_WIDTH].
- `wr_ready_o`  out  1  write accepted when high with `wr_req_i`.
- `rd_req_i`  in  1  read request valid.
- `rd_addr_i`  in  BUS_ADDR_WIDTH  byte address.
- `rd_ready_o`  out  1  read accepted when high with `rd_req_i`.
- `rd_data_o`  out  DATA_WIDTH  read data.
- `rd_valid_o`  out  1  one-cycle pulse qualifying `rd_data_o`.
- `err_o`  out  1  one-cycle pulse for an out-of-range access.

## Operation
- Word index = `addr[RAM_ADDR_WIDTH-1 : log2(NUM_LANES)]`. Low lane bits are ignored; callers pre-shift strobes.
- Out of range: any of `addr[BUS_ADDR_WIDTH-1:RAM_ADDR_WIDTH]` is nonzero.
  - Write: dropped.
  - Read: returns all-zero data with `rd_valid_o`.
  - Either raises `err_o` at the same cycle `rd_valid_o` would fire. For writes, that is the cycle after acceptance.
- Handshake: a request fires when req && ready. The ready signals depend only on FSM state, never on req. There is no response backpressure.
- FSM states:
  - CLEAR: entered on reset if `CLEAR_ON_RESET`=1. Counter `clr_idx` runs 0..DEPTH-1 and writes zero to all lanes, one word per cycle. Both ready signals are low. Moves to RUN after writing index DEPTH-1.
  - RUN: both ready signals are high. Stays in RUN until reset.
  - If `CLEAR_ON_RESET`=0, reset state is RUN, but ready stays low until the first clock edge after `rst_n` deassertion.
- Reset asserted mid-CLEAR restarts the sequence from index 0 when released.
- Read-during-write, same word index, same cycle:
  - Lanes with strobe set return the new data (write-first).
  - Other lanes return stored data.
- A write accepted after a read issues never alters that read's result, including with `OUT_REG`=1.
- Strobe all-zero with `wr_req_i`: accepted as a no-op; memory is unchanged.

## Timing
- Reset values: `rd_data_o`=0, `rd_valid_o`=0, `err_o`=0, `wr_ready_o`=0, `rd_ready_o`=0, FSM=CLEAR (or RUN per parameter), `clr_idx`=0. Memory contents are not reset.
- Read latency: read accepted in cycle N gives `rd_valid_o` in N+1 (`OUT_REG`=0) or N+2 (`OUT_REG`=1).
- Throughput: one read and one write per cycle.
- `rd_data_o` holds its last value between valid pulses.
- Write visible to a read of the same index issued in the same or any later cycle.
- Clear duration: DEPTH cycles from the first edge after reset release; ready rises on cycle DEPTH+1.

## Structure
- Shared package `ram_pkg`:
  - default widths `DATA_WIDTH`, `RV32_ADDR_WIDTH`, `RAM_ADDR_WIDTH`;
  - FSM state enum {CLEAR, RUN};
  - helper `lane_count(DATA_WIDTH, LANE_WIDTH)`.
- Sub-module `sdp_bram_lane`:
  - simple dual-port, LANE_WIDTH × DEPTH;
  - sync write, sync read, no data reset;
  - instantiated NUM_LANES times via generate.
- Clear mux, forwarding compare, and output pipeline live in the top level.

## Test plan
- Reset with DEPTH=1024 → ready stays low for exactly 1024 cycles. Any read afterwards returns 0x00000000.
- Write 0xDEADBEEF to 0x010 with strobe 4'b1111. Then write 0x000000AA with strobe 4'b0001. Read 0x010 → 0xDEADBEAA, `rd_valid_o` one cycle later (two with `OUT_REG`=1).
- Same cycle: write 0x11223344 with strobe 4'b0110 to 0x020, which holds 0xAABBCCDD, and read 0x020 → 0xAA2233DD.
- Read 0x00001000 (bit 12 set) → data 0, `rd_valid_o` and `err_o` pulse together. A write to 0x00002004 leaves memory unchanged and pulses `err_o`.
- Assert `rst_n` low at clear index 500, release → clear restarts at 0 and takes a full DEPTH cycles.
- Back-to-back reads of 0x000, 0x004, 0x008 on consecutive cycles → three consecutive `rd_valid_o` pulses with matching data.
